// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared format codes, opcodes and sign-extension helper for imm_gen_pipe
package imm_gen_pkg;

  typedef logic [2:0] fmt_t;

  localparam fmt_t FMT_NONE = 3'd0;
  localparam fmt_t FMT_I    = 3'd1;
  localparam fmt_t FMT_S    = 3'd2;
  localparam fmt_t FMT_B    = 3'd3;
  localparam fmt_t FMT_U    = 3'd4;
  localparam fmt_t FMT_J    = 3'd5;
  localparam fmt_t FMT_Z    = 3'd6;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;

  // Immediates are assembled at 32 bits, widened to the largest XLEN, then truncated by the user.
  localparam int MAX_XLEN = 64;

  function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MAX_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_pipe_stage.sv
// rtl/imm_pipe_stage.sv - one elastic valid/ready register slice with synchronous flush
module imm_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Refusing input while flushing keeps a new entry from slipping in behind the drop.
  assign in_ready = !flush && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32I immediate decoder with elastic pipeline; IMM_GEN_ZICSR_EN adds CSR-immediate format
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int W = XLEN + 4;

  fmt_t        dec_fmt;
  logic        dec_ill;
  logic [31:0] raw;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    raw     = '0;
    if (in_instr[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (in_instr[6:0])
        OP_LUI, OP_AUIPC:                        dec_fmt = FMT_U;
        OP_JAL:                                  dec_fmt = FMT_J;
        OP_JALR, OP_LOAD, OP_OPIMM, OP_MISC_MEM: dec_fmt = FMT_I;
`ifdef IMM_GEN_ZICSR_EN
        OP_SYSTEM:                               dec_fmt = in_instr[14] ? FMT_Z : FMT_I;
`else
        OP_SYSTEM:                               dec_fmt = FMT_I;
`endif
        OP_STORE:                                dec_fmt = FMT_S;
        OP_BRANCH:                               dec_fmt = FMT_B;
        OP_OP:                                   dec_fmt = FMT_NONE;
        default:                                 dec_ill = 1'b1;
      endcase
    end
    case (dec_fmt)
      FMT_I:   raw = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   raw = {in_instr[31:12], 12'b0};
      FMT_J:   raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z:   raw = {27'b0, in_instr[19:15]};
      default: raw = '0;
    endcase
  end

  assign dec_imm = XLEN'(sext32(raw));

  logic [PIPE_DEPTH:0] vld;
  logic [W-1:0]        dat [PIPE_DEPTH+1];

  assign vld[0] = in_valid;
  assign dat[0] = {dec_imm, dec_fmt, dec_ill};

  // Ready travels backwards through per-stage signals so the chain stays combinational from out_ready.
  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    logic up_ready;
    logic down_ready;
    if (g == PIPE_DEPTH - 1) begin : g_last
      assign down_ready = out_ready;
    end else begin : g_mid
      assign down_ready = g_stage[g+1].up_ready;
    end
    imm_pipe_stage #(.W(W)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld[g]),
      .in_ready  (up_ready),
      .in_data   (dat[g]),
      .out_valid (vld[g+1]),
      .out_ready (down_ready),
      .out_data  (dat[g+1])
    );
  end

  assign in_ready = g_stage[0].up_ready;
  assign out_valid = vld[PIPE_DEPTH];
  assign {out_imm, out_fmt, out_illegal} = dat[PIPE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (clr_cnt) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && out_illegal && !flush && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_ready, a_ovalid, a_oready = 1, a_ill, a_flush = 0, a_clr = 0;
  logic [31:0] a_instr = 0, a_imm;
  logic [2:0]  a_fmt;
  logic [1:0]  a_cnt;

  logic        b_valid = 0, b_ready, b_ovalid, b_oready = 1, b_ill, b_flush = 0, b_clr = 0;
  logic [31:0] b_instr = 0;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;

  imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_instr(a_instr),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .flush(a_flush), .clr_cnt(a_clr), .illegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_instr(b_instr),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill), .flush(b_flush), .clr_cnt(b_clr), .illegal_cnt(b_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic a_send(input logic [31:0] instr);
    a_instr = instr;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  typedef struct { logic [31:0] instr; logic [31:0] imm; logic [2:0] fmt; logic ill; string tag; } vec_t;
  vec_t vecs [7];

  logic [31:0] stream [4];
  logic [63:0] got_q [$];
  int sent;
  logic fire_in;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, "addi"};
    vecs[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, "sw"};
    vecs[2] = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0, "lui"};
    vecs[3] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, "beq"};
    vecs[4] = '{32'h008000EF, 32'h00000008, 3'd5, 1'b0, "jal"};
    vecs[5] = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, "add"};
    vecs[6] = '{32'h0000007C, 32'h00000000, 3'd0, 1'b1, "bad_lsb"};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_a_ovalid", a_ovalid, 0);
    check("rst_a_imm", a_imm, 0);
    check("rst_a_fmt", a_fmt, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ovalid", b_ovalid, 0);
    check("rst_b_ready", b_ready, 1);

    foreach (vecs[i]) begin
      a_send(vecs[i].instr);
      check({vecs[i].tag, "_valid"}, a_ovalid, 1);
      check({vecs[i].tag, "_imm"}, a_imm, vecs[i].imm);
      check({vecs[i].tag, "_fmt"}, a_fmt, vecs[i].fmt);
      check({vecs[i].tag, "_ill"}, a_ill, vecs[i].ill);
    end

    a_send(32'h3002D073);
`ifdef IMM_GEN_ZICSR_EN
    check("csr_imm", a_imm, 32'h5);
    check("csr_fmt", a_fmt, 3'd6);
`else
    check("csr_imm", a_imm, 32'h300);
    check("csr_fmt", a_fmt, 3'd1);
`endif

    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    check("clr_cnt", a_cnt, 0);

    a_instr = 32'h0;
    a_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("sat_ill", a_ill, 1);
      check("sat_imm", a_imm, 0);
      check("sat_cnt", a_cnt, (k - 1 > 3) ? 3 : k - 1);
    end
    a_valid = 1'b0;
    @(posedge clk); #1;
    check("sat_cnt_final", a_cnt, 3);

    a_send(32'h0);
    check("clr_pri_pre", a_ovalid, 1);
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    check("clr_pri_cnt", a_cnt, 0);
    check("clr_pri_ovalid", a_ovalid, 0);

    a_flush = 1'b1;
    #1 check("flush_a_ready", a_ready, 0);
    @(posedge clk); #1;
    a_flush = 1'b0;
    #1 check("flush_a_ready_after", a_ready, 1);

    stream[0] = 32'h00100093;
    stream[1] = 32'h00200093;
    stream[2] = 32'h00300093;
    stream[3] = 32'h00400093;
    sent = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      b_oready = (cyc >= 5);
      b_valid  = (sent < 4);
      b_instr  = (sent < 4) ? stream[sent] : 32'h0;
      #1;
      if (cyc == 4) begin
        check("bp_in_ready", b_ready, 0);
        check("bp_sent", sent, 2);
        check("bp_ovalid", b_ovalid, 1);
        check("bp_hold_imm", b_imm, 64'h1);
      end
      fire_in = b_valid & b_ready;
      if (b_ovalid && b_oready) got_q.push_back(b_imm);
      @(posedge clk); #1;
      if (fire_in) sent++;
    end
    b_valid = 1'b0;
    check("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < got_q.size()) ? got_q[i] : 64'hDEAD, 64'(i + 1));
    check("bp_drained", b_ovalid, 0);

    b_oready = 1'b1;
    b_instr = 32'h800002B7;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(posedge clk); #1;
    check("lui64_valid", b_ovalid, 1);
    check("lui64_imm", b_imm, 64'hFFFFFFFF80000000);
    check("lui64_fmt", b_fmt, 3'd4);

    b_instr = 32'h0;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_oready = 1'b0;
    @(posedge clk); #1;
    b_valid = 1'b0;
    #1;
    check("fl_full_ovalid", b_ovalid, 1);
    check("fl_full_ill", b_ill, 1);
    check("fl_full_ready", b_ready, 0);
    b_flush = 1'b1;
    #1 check("fl_in_ready", b_ready, 0);
    @(posedge clk); #1;
    b_flush = 1'b0;
    check("fl_ovalid", b_ovalid, 0);
    check("fl_cnt", b_cnt, 0);
    b_oready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("fl_ovalid_later", b_ovalid, 0);
    check("fl_cnt_later", b_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the opcode-only immediate-select decoder.
- Takes a full 32-bit RV32I instruction over a valid/ready handshake and decodes its immediate format.
- Produces the sign-extended XLEN-bit immediate after PIPE_DEPTH elastic register stages.
- Sits between fetch and the execute-stage operand mux; also flags illegal opcodes and counts them.

Parameters:
- XLEN, 32, immediate output width; only 32 or 64 are legal.
- PIPE_DEPTH, 1, number of elastic register stages (1..4); this is also the latency.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage 0 can accept
- in_instr  in  32  raw instruction
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6
- out_illegal  out  1  opcode not recognised
- flush  in  1  synchronous drop of all in-flight entries
- clr_cnt  in  1  synchronous counter clear
- illegal_cnt  out  CNT_W  saturating count of illegal results delivered

Behaviour:
- Reset (async, rst=1):
  - all stage valid bits 0, so out_valid=0
  - out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0
  - in_ready=1 once rst is released
- Decode is combinational on in_instr ahead of stage 0; later stages only delay.
- Opcode to format map:
  - LUI 0110111 and AUIPC 0010111 -> U
  - JAL 1101111 -> J
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011 -> I
  - STORE 0100011 -> S
  - BRANCH 1100011 -> B
  - OP 0110011 -> NONE with imm=0, legal
  - anything else, or in_instr[1:0]!=2'b11 -> NONE, imm=0, illegal=1
- Immediate assembly (sext sign-extends to XLEN):
  - I = sext(i[31:20])
  - S = sext({i[31:25], i[11:7]})
  - B = sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
  - U = sext({i[31:12], 12'b0}); with XLEN=64, bits 63:32 copy i[31]
  - J = sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
- Elastic pipeline:
  - stage k ready = !valid_k | ready_(k+1); the last stage's downstream ready is out_ready
  - transfer on valid&ready; full throughput, no bubbles; order preserved
  - in_ready is combinational through the chain from out_ready
  - data is held stable while out_valid=1 and out_ready=0
- Flush:
  - flush=1 clears every valid bit at the next edge and drops in-flight entries
  - in_ready=0 during the flush cycle, so no input is accepted that cycle
  - a flushed entry never increments the counter
- Counter:
  - +1 when out_valid & out_ready & out_illegal
  - saturates at all-ones
  - clr_cnt has priority over increment in the same cycle: result is 0
- Reset mid-stream: entries are lost immediately (async), and the counter is zeroed.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: SYSTEM opcode with funct3[2]=1 gives fmt=Z and imm = zero-extended i[19:15].
- Undefined: all SYSTEM encodings give fmt=I with the I-type immediate. Code 6 is never produced.

Decomposition:
- Shared package imm_gen_pkg holds:
  - fmt code constants (NONE..Z) and the 3-bit fmt typedef
  - the opcode localparams
  - the sign-extension width rule
- One natural sub-module: imm_pipe_stage, a single valid/ready register slice carrying {imm, fmt, illegal}.
- The top level instantiates PIPE_DEPTH copies via a generate loop, plus the decode logic and the counter.

Test Plan:
1. XLEN=32, PIPE_DEPTH=1, in_instr=0xFFF00093 (addi x1,x0,-1) -> one cycle later out_imm=0xFFFFFFFF, fmt=1, illegal=0.
2. in_instr=0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt=2; in_instr=0x123452B7 (lui x5,0x12345) -> out_imm=0x12345000, fmt=4.
3. PIPE_DEPTH=2, stream of 4 instructions, out_ready=0 for 5 cycles -> in_ready drops after 2 are held; after release all 4 emerge in order with none lost or duplicated.
4. CNT_W=2, five back-to-back 0x00000000 accepted -> each output has out_illegal=1, imm=0; illegal_cnt reads 1,2,3,3,3; clr_cnt together with an illegal transfer -> 0.
5. XLEN=64, in_instr=0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000; flush with 2 entries in flight -> out_valid=0 next cycle and illegal_cnt unchanged.
6. in_instr=0x3002D073 (csrrwi x0,mstatus,5) -> with IMM_GEN_ZICSR_EN: imm=5, fmt=6; without it: imm=0x300, fmt=1.
